// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: drains the UART TX FIFO and serializes each byte as start/data/parity/stop on txd
module uart_tx_ctrl #(
  parameter int DWIDTH = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_par_en,
  input  logic                 cfg_par_odd,
  input  logic                 cfg_stop2,
  input  logic                 fifo_empty,
  input  logic [DWIDTH-1:0]    fifo_rdata,
  output logic                 fifo_rd,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BW = $clog2(DWIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DIV_WIDTH-1:0] cnt, div_q;
  logic [BW-1:0] bit_cnt;
  logic [DWIDTH-1:0] sh;
  logic par_en_q, par_q, stop2_q;
  logic last_bit, data_last, frame_end, start;
  assign last_bit = cnt == '0;
  assign data_last = bit_cnt == BW'(DWIDTH - 1);
  assign frame_end = state == STOP && last_bit && bit_cnt == BW'(stop2_q);
  assign start = tx_en && !fifo_empty && (state == IDLE || frame_end);
  assign fifo_rd = start && !rst;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: each bit boundary advances the frame, the final stop bit either restarts or idles
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? START : IDLE;
      START:   state_n = last_bit ? DATA : START;
      DATA:    state_n = last_bit && data_last ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_n = last_bit ? STOP : PARITY;
      STOP:    state_n = frame_end ? (start ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // datapath: pop/latch on start, baud countdown, shift LSB first, registered txd and status
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      div_q <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      stop2_q <= 1'b0;
      txd <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      tx_done <= frame_end;
      if (start) begin
        sh <= fifo_rdata;
        div_q <= cfg_div;
        par_en_q <= cfg_par_en;
        par_q <= cfg_par_odd ? ~^fifo_rdata : ^fifo_rdata;
        stop2_q <= cfg_stop2;
        cnt <= cfg_div;
        bit_cnt <= '0;
        txd <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= last_bit ? div_q : cnt - DIV_WIDTH'(1);
        if (last_bit) begin
          if (state == START) begin
            txd <= sh[0];
            bit_cnt <= '0;
          end else if (state == DATA) begin
            txd <= data_last ? (par_en_q ? par_q : 1'b1) : sh[1];
            sh <= sh >> 1;
            bit_cnt <= data_last ? '0 : bit_cnt + BW'(1);
          end else if (state == PARITY) begin
            txd <= 1'b1;
            bit_cnt <= '0;
          end else begin
            txd <= 1'b1;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench comparing txd/busy/tx_done/fifo_rd against a per-clock frame model
module tb_uart_tx_ctrl;
  logic clk = 1'b0, rst = 1'b1, tx_en = 1'b0;
  logic cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic fifo_rd, txd, busy, tx_done;
  typedef struct packed {logic t; logic l;} ent_t;
  ent_t exp_q[$];
  logic [7:0] fq[$];
  int n_chk = 0, n_fail = 0;
  logic pend = 1'b0;
  ent_t e;
  logic et, eb, el, erd;
  logic [7:0] b;
  int nb;
  uart_tx_ctrl #(.DWIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .cfg_div(cfg_div), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .txd(txd), .busy(busy), .tx_done(tx_done)
  );
  // free-running clock
  always #5 clk = ~clk;
  function automatic logic frame_bit(input logic [7:0] d, input int i, input logic pe, input logic po);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && pe) return po ? ~^d : ^d;
    return 1'b1;
  endfunction
  task automatic chk(input string nm, input logic a, input logic x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, x);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((fq.size() > 0 || exp_q.size() > 0) && n < lim) begin
      tick(1);
      n++;
    end
    if (n >= lim) begin
      $display("FAIL drain timeout: fifo %0d expected-queue %0d", fq.size(), exp_q.size());
      $fatal(1);
    end
  endtask
  // show-ahead FIFO model presented to the DUT, updated just after each edge
  always @(posedge clk) begin
    #1;
    fifo_empty = fq.size() == 0;
    fifo_rdata = fifo_empty ? 8'h00 : fq[0];
  end
  // monitor: compare one expected clock of txd per cycle, predict pops and queue each new frame
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend = 1'b0;
      chk("rst_txd", txd, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      chk("rst_rd", fifo_rd, 1'b0);
    end else begin
      et = 1'b1;
      eb = 1'b0;
      el = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        et = e.t;
        eb = 1'b1;
        el = e.l;
      end
      chk("txd", txd, et);
      chk("busy", busy, eb);
      chk("tx_done", tx_done, pend);
      pend = el;
      erd = tx_en && !fifo_empty && exp_q.size() == 0;
      chk("fifo_rd", fifo_rd, erd);
      if (erd) begin
        b = fq.pop_front();
        nb = 10 + int'(cfg_par_en) + int'(cfg_stop2);
        for (int i = 0; i < nb; i++)
          for (int k = 0; k <= int'(cfg_div); k++)
            exp_q.push_back('{t: frame_bit(b, i, cfg_par_en, cfg_par_odd), l: (i == nb - 1 && k == int'(cfg_div))});
      end
    end
  end
  // directed scenarios followed by randomized traffic
  initial begin
    int r;
    tick(3);
    rst = 1'b0;
    tick(2);
    cfg_div = 16'd3;
    tx_en = 1'b1;
    fq.push_back(8'hA5);
    drain(2000);
    tick(5);
    cfg_par_en = 1'b1;
    fq.push_back(8'h07);
    drain(2000);
    cfg_par_odd = 1'b1;
    fq.push_back(8'h07);
    drain(2000);
    cfg_stop2 = 1'b1;
    fq.push_back(8'h07);
    drain(2000);
    tick(3);
    cfg_par_en = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2 = 1'b0;
    cfg_div = 16'd0;
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    drain(2000);
    tick(3);
    cfg_div = 16'd3;
    fq.push_back(8'h3C);
    fq.push_back(8'h5A);
    fq.push_back(8'hF0);
    tick(12);
    tx_en = 1'b0;
    tick(80);
    tx_en = 1'b1;
    drain(2000);
    tick(20);
    fq.push_back(8'h96);
    tick(14);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    fq.push_back(8'h69);
    drain(2000);
    tick(3);
    fq.push_back(8'hC3);
    fq.push_back(8'h3C);
    tick(10);
    cfg_div = 16'd7;
    drain(2000);
    tick(3);
    repeat (3000) begin
      tick(1);
      r = $urandom_range(0, 99);
      if (r < 8 && fq.size() < 4) fq.push_back(8'($urandom));
      if (r == 10) cfg_div = 16'($urandom_range(0, 3));
      if (r == 11) cfg_par_en = 1'($urandom);
      if (r == 12) cfg_par_odd = 1'($urandom);
      if (r == 13) cfg_stop2 = 1'($urandom);
      if (r >= 14 && r <= 16) tx_en = $urandom_range(0, 3) != 0;
      if (r == 17 && $urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    tx_en = 1'b1;
    drain(2000);
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
